layer_4_maxpool2x2: RTL and testbench

- Downstream stage of the layer-4 feature-map convolution.
- Consumes the raster-ordered IEEE-754 single-precision feature-map stream that a layer_4 featuremap block produces, one pixel per valid beat.
- Performs 2x2 max-pooling with stride 2, halving each spatial dimension (104x104 -> 52x52).
- Emits the pooled stream with the same valid-only (no back-pressure) convention as the producer.

---
 rtl/layer_4_maxpool2x2_if.sv | 27 ++
 rtl/layer_4_maxpool2x2.sv | 107 ++++++++++
 tb/tb_layer_4_maxpool2x2.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_4_maxpool2x2_if.sv
// Valid-only pixel stream bundle for the layer-4 2x2 max-pool stage.
// The master side feeds pixels in and observes pooled pixels out.
interface layer_4_maxpool2x2_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  frame_done;

  modport master (
    output data_in,
    output valid_in,
    input  data_out,
    input  valid_out,
    input  frame_done
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output data_out,
    output valid_out,
    output frame_done
  );
endinterface

// File: rtl/layer_4_maxpool2x2.sv
// 2x2 stride-2 max-pool over a raster float32 stream; horizontal pairs are reduced in a
// hold register, even-row results are parked in a half-width line buffer for the odd row.
module layer_4_maxpool2x2 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMG_SIZE   = 104
) (
  input  logic                 Clk,
  input  logic                 Rst,
  layer_4_maxpool2x2_if.slave  bus
);

  localparam int unsigned CW   = $clog2(IMG_SIZE);
  localparam int unsigned HALF = IMG_SIZE / 2;
  localparam int unsigned AW   = CW - 1;

  if (IMG_SIZE % 2 != 0) begin : g_bad_size
    $error("layer_4_maxpool2x2: IMG_SIZE must be even");
  end

  // Bit-pattern float max; NaNs fall wherever their encoding lands, ties return a.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
      return a[DATA_WIDTH-1] ? b : a;
    end else if (!a[DATA_WIDTH-1]) begin
      return (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) ? b : a;
    end else begin
      return (b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0]) ? b : a;
    end
  endfunction

  logic [CW-1:0]         col_q, col_d, row_q, row_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  vout_q, vout_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] linebuf_q [HALF];

  logic [AW-1:0]         lb_addr;
  logic                  lb_we;
  logic [DATA_WIDTH-1:0] lb_rd;
  logic [DATA_WIDTH-1:0] h;
  logic                  col_last, row_last;

  assign lb_addr  = col_q[CW-1:1];
  assign lb_rd    = linebuf_q[lb_addr];
  assign h        = fmax(hold_q, bus.data_in);
  assign col_last = (col_q == CW'(IMG_SIZE - 1));
  assign row_last = (row_q == CW'(IMG_SIZE - 1));

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hold_d = hold_q;
    out_d  = out_q;
    vout_d = 1'b0;
    done_d = 1'b0;
    lb_we  = 1'b0;
    if (bus.valid_in) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (!col_q[0]) begin
        hold_d = bus.data_in;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_d  = fmax(lb_rd, h);
        vout_d = 1'b1;
        done_d = col_last && row_last;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      col_q  <= '0;
      row_q  <= '0;
      hold_q <= '0;
      out_q  <= '0;
      vout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      hold_q <= hold_d;
      out_q  <= out_d;
      vout_q <= vout_d;
      done_q <= done_d;
    end
  end

  // Never read before written: odd-row reads always follow the even-row write of the frame.
  always_ff @(posedge Clk) begin
    if (lb_we) begin
      linebuf_q[lb_addr] <= h;
    end
  end

  assign bus.data_out   = out_q;
  assign bus.valid_out  = vout_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_layer_4_maxpool2x2.sv
// Bench for layer_4_maxpool2x2: a 4x4 instance for directed/gapped/reset cases and a
// default 104x104 instance for back-to-back random frames, against a frame-level model.
module tb_layer_4_maxpool2x2;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_s, rst_b;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   hold_s = 1'b0;
  bit   hold_b = 1'b0;
  logic [31:0] last_s = '0;
  logic [31:0] last_b = '0;
  exp_t exp_s[$];
  exp_t exp_b[$];
  exp_t e_s, e_b;
  logic [31:0] obs_s[$];
  logic [31:0] frame [];
  int   out_b = 0;
  int   fd_b = 0;

  layer_4_maxpool2x2_if #(.DATA_WIDTH(32)) sif ();
  layer_4_maxpool2x2_if #(.DATA_WIDTH(32)) bif ();

  layer_4_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(4)) u_small (
    .Clk (clk),
    .Rst (rst_s),
    .bus (sif.slave)
  );

  layer_4_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(104)) u_big (
    .Clk (clk),
    .Rst (rst_b),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Order-preserving key: comparing keys as unsigned matches the float bit-pattern max rule.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [31:0] fmax_ref(input logic [31:0] a, input logic [31:0] b);
    return (fkey(b) > fkey(a)) ? b : a;
  endfunction

  function automatic logic [31:0] flt(input int i);
    case (i)
      1:  return 32'h3F80_0000;
      2:  return 32'h4000_0000;
      3:  return 32'h4040_0000;
      4:  return 32'h4080_0000;
      5:  return 32'h40A0_0000;
      6:  return 32'h40C0_0000;
      7:  return 32'h40E0_0000;
      8:  return 32'h4100_0000;
      9:  return 32'h4110_0000;
      10: return 32'h4120_0000;
      11: return 32'h4130_0000;
      12: return 32'h4140_0000;
      13: return 32'h4150_0000;
      14: return 32'h4160_0000;
      15: return 32'h4170_0000;
      default: return 32'h4180_0000;
    endcase
  endfunction

  task automatic drive(input bit big, input bit v, input logic [31:0] d);
    if (big) begin
      bif.valid_in = v;
      bif.data_in  = d;
    end else begin
      sif.valid_in = v;
      sif.data_in  = d;
    end
  endtask

  // Sends frame[] raster-order; the expected pooled pixel is the max of its four inputs,
  // due one cycle after the bottom-right beat.
  task automatic send_frame(input bit big, input int n, input int gap_pct);
    exp_t x;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          @(posedge clk); #1;
          drive(big, 1'b0, $urandom);
        end
        @(posedge clk); #1;
        drive(big, 1'b1, frame[r*n+c]);
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          x.due  = cyc + 1;
          x.data = fmax_ref(fmax_ref(frame[(r-1)*n+c-1], frame[(r-1)*n+c]),
                            fmax_ref(frame[r*n+c-1], frame[r*n+c]));
          x.last = (r == n-1) && (c == n-1);
          if (big) exp_b.push_back(x);
          else     exp_s.push_back(x);
        end
      end
    end
  endtask

  task automatic idle(input int k);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic expect4(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
    check({tag, "_count"}, obs_s.size(), 4);
    if (obs_s.size() == 4) begin
      check({tag, "_0"}, obs_s[0], a);
      check({tag, "_1"}, obs_s[1], b);
      check({tag, "_2"}, obs_s[2], c);
      check({tag, "_3"}, obs_s[3], d);
    end
    obs_s.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_s.size() != 0 && exp_s[0].due == cyc) begin
        e_s = exp_s.pop_front();
        check("s_valid", {31'b0, sif.valid_out}, 1);
        check("s_data", sif.data_out, e_s.data);
        check("s_done", {31'b0, sif.frame_done}, {31'b0, e_s.last});
        last_s = e_s.data;
      end else begin
        check("s_idle_valid", {31'b0, sif.valid_out}, 0);
        check("s_idle_done", {31'b0, sif.frame_done}, 0);
        if (hold_s) check("s_hold", sif.data_out, last_s);
      end
      if (sif.valid_out) obs_s.push_back(sif.data_out);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_b.size() != 0 && exp_b[0].due == cyc) begin
        e_b = exp_b.pop_front();
        check("b_valid", {31'b0, bif.valid_out}, 1);
        check("b_data", bif.data_out, e_b.data);
        check("b_done", {31'b0, bif.frame_done}, {31'b0, e_b.last});
        last_b = e_b.data;
      end else begin
        check("b_idle_valid", {31'b0, bif.valid_out}, 0);
        check("b_idle_done", {31'b0, bif.frame_done}, 0);
        if (hold_b) check("b_hold", bif.data_out, last_b);
      end
      if (bif.valid_out) out_b++;
      if (bif.frame_done) fd_b++;
    end
  end

  initial begin
    rst_s = 1'b1;
    rst_b = 1'b1;
    drive(1'b0, 1'b1, 32'h4120_0000);
    drive(1'b1, 1'b1, 32'h4120_0000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_valid", {31'b0, sif.valid_out}, 0);
    check("rst_s_done", {31'b0, sif.frame_done}, 0);
    check("rst_s_data", sif.data_out, 0);
    check("rst_b_valid", {31'b0, bif.valid_out}, 0);
    check("rst_b_data", bif.data_out, 0);
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    rst_s  = 1'b0;
    rst_b  = 1'b0;
    hold_s = 1'b1;
    hold_b = 1'b1;
    mon_en = 1'b1;

    // Ascending 1..16, continuous valid.
    frame = new[16];
    for (int i = 0; i < 16; i++) frame[i] = flt(i + 1);
    send_frame(1'b0, 4, 0);
    idle(3);
    expect4("pos", 32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000);

    // Negated 1..16.
    for (int i = 0; i < 16; i++) frame[i] = flt(i + 1) | 32'h8000_0000;
    send_frame(1'b0, 4, 0);
    idle(3);
    expect4("neg", 32'hBF80_0000, 32'hC040_0000, 32'hC110_0000, 32'hC130_0000);

    // Signed zeros vs negatives, and a window of equal values.
    for (int i = 0; i < 16; i++) frame[i] = $urandom;
    frame[0] = 32'h8000_0000;
    frame[1] = 32'h0000_0000;
    frame[4] = 32'hBF80_0000;
    frame[5] = 32'hC000_0000;
    frame[2] = 32'h3F80_0000;
    frame[3] = 32'h3F80_0000;
    frame[6] = 32'h3F80_0000;
    frame[7] = 32'h3F80_0000;
    send_frame(1'b0, 4, 0);
    idle(3);
    check("zero_count", obs_s.size(), 4);
    if (obs_s.size() == 4) begin
      check("zero_win", obs_s[0], 32'h0000_0000);
      check("equal_win", obs_s[1], 32'h3F80_0000);
    end
    obs_s.delete();

    // Ascending frame with ~50% valid gaps.
    for (int i = 0; i < 16; i++) frame[i] = flt(i + 1);
    send_frame(1'b0, 4, 50);
    idle(3);
    expect4("gaps", 32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000);

    // Mid-frame reset after 5 accepted beats (valid_in high during reset is ignored).
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b1, flt(16 - i));
    end
    @(posedge clk); #1;
    rst_s  = 1'b1;
    hold_s = 1'b0;
    drive(1'b0, 1'b1, 32'h4120_0000);
    @(posedge clk); #1;
    rst_s  = 1'b0;
    last_s = '0;
    hold_s = 1'b1;
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) frame[i] = flt(i + 1);
    send_frame(1'b0, 4, 0);
    idle(3);
    expect4("rst_mid", 32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000);

    // Two back-to-back random 104x104 frames; a small value pool forces ties.
    frame = new[104*104];
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 104*104; i++) begin
        frame[i] = ($urandom_range(3) == 0) ? {$urandom_range(1), 31'h3F80_0000}
                                            : $urandom;
      end
      send_frame(1'b1, 104, 0);
    end
    idle(4);
    check("b_out_count", out_b, 2 * 2704);
    check("b_frame_done_count", fd_b, 2);
    check("s_pending", exp_s.size(), 0);
    check("b_pending", exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
